pong_game_ctrl: RTL

Game-level sequencer for the pong ball datapath. It gates ball motion, recenters the ball after each point, detects misses against the left and right borders, keeps both scores, and halts play at the winning score. It sits above the ball state machine / ball position logic and beside the paddle blocks. Its outputs drive the ball's move enable and recenter inputs, and the score display.

---
 rtl/pong_pkg.sv | 28 ++
 rtl/pong_game_ctrl_frame_pause_counter.sv | 40 ++++
 rtl/pong_game_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared types and constants for the pong game-level control blocks.
//   game_state_t : 2-bit encoding of the game sequencer states
//   SCORE_W      : width of each player score
//   COORD_W      : default width of horizontal coordinates
//   PAUSE_CNT_W  : width of the frame-pause counter (covers up to 255 frames)
//   score_inc    : saturating score increment (sticks at all-ones)
// ---------------------------------------------------------------------------
package pong_pkg;

   localparam int SCORE_W     = 4;
   localparam int COORD_W     = 10;
   localparam int PAUSE_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2,
      OVER  = 2'd3
   } game_state_t;

   // Scores never wrap; at all-ones they stay put.
   function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
      return (s == {SCORE_W{1'b1}}) ? s : s + 1'b1;
   endfunction

endpackage

// File: rtl/pong_game_ctrl_frame_pause_counter.sv
// ---------------------------------------------------------------------------
// frame_pause_counter
// Counts frame_tick pulses; flags the tick on which the count has reached
// TERM-1 and rolls back to zero on that tick.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset, count -> 0
//   clear    : synchronous clear, holds count at 0 while high
//   tick     : count enable (one-cycle frame pulse)
//   terminal : high on the tick that completes TERM counted ticks
// ---------------------------------------------------------------------------
module frame_pause_counter
   import pong_pkg::*;
#(
   parameter int W    = PAUSE_CNT_W,
   parameter int TERM = 60
)(
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   output logic terminal
);

   logic [W-1:0] count;

   // Terminal is qualified by tick so the owner can act on it directly.
   assign terminal = tick & (count == W'(TERM - 1));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (terminal) begin
         count <= '0;
      end else if (tick) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl
// Game-level sequencer: gates ball motion, recentres the ball after each
// point, detects misses at the horizontal borders, keeps both scores and
// stops play once a player reaches WIN_SCORE.
// Ports:
//   CLK_100MHz             : system clock, rising edge
//   Reset                  : synchronous active-high reset
//   frame_tick             : one-cycle pulse per video frame
//   serve_btn              : debounced serve button level
//   BHmin, BHmax           : ball horizontal extent
//   borderHmin, borderHmax : playfield inner horizontal edges
//   ball_run               : ball may move (state PLAY)
//   ball_center            : one-cycle recentre pulse
//   serve_dir              : 0 = serve toward left player, 1 = toward right
//   score_L, score_R       : player scores
//   game_over              : high in state OVER
// Build option:
//   AUTO_SERVE_EN : pause expiry resumes play directly instead of waiting
//                   in IDLE for a serve press.
// ---------------------------------------------------------------------------
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = 7,
   parameter int PAUSE_FRAMES = 60,
   parameter int CW           = COORD_W
)(
   input  logic               CLK_100MHz,
   input  logic               Reset,
   input  logic               frame_tick,
   input  logic               serve_btn,
   input  logic [CW-1:0]      BHmin,
   input  logic [CW-1:0]      BHmax,
   input  logic [CW-1:0]      borderHmin,
   input  logic [CW-1:0]      borderHmax,
   output logic               ball_run,
   output logic               ball_center,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] score_L,
   output logic [SCORE_W-1:0] score_R,
   output logic               game_over
);

   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

   game_state_t        state, state_nxt;
   logic               serve_btn_q;
   logic               serve_press;
   logic               pause_done;
   logic               pause_clear;
   logic [SCORE_W-1:0] score_l_inc, score_r_inc;
   logic [SCORE_W-1:0] score_l_nxt, score_r_nxt;
   logic               serve_dir_nxt;
   logic               center_nxt;

   // A held button only produces a single serve request.
   assign serve_press = serve_btn & ~serve_btn_q;

   assign score_l_inc = score_inc(score_L);
   assign score_r_inc = score_inc(score_R);

   assign ball_run  = (state == PLAY);
   assign game_over = (state == OVER);

   // The pause counter only runs in PAUSE, so it always starts from zero.
   assign pause_clear = (state != PAUSE);

   frame_pause_counter #(
      .W    (PAUSE_CNT_W),
      .TERM (PAUSE_FRAMES)
   ) u_pause_cnt (
      .clk      (CLK_100MHz),
      .reset    (Reset),
      .clear    (pause_clear),
      .tick     (frame_tick),
      .terminal (pause_done)
   );

   // Next-state and next-score logic. Misses are only judged on frame ticks;
   // the left border is checked first so a ball touching both edges in one
   // tick awards exactly one point, to the right player.
   always_comb begin
      state_nxt     = state;
      score_l_nxt   = score_L;
      score_r_nxt   = score_R;
      serve_dir_nxt = serve_dir;
      center_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (serve_press) begin
               state_nxt = PLAY;
            end
         end
         PLAY: begin
            if (frame_tick) begin
               if (BHmin <= borderHmin) begin
                  score_r_nxt   = score_r_inc;
                  serve_dir_nxt = 1'b0;
                  center_nxt    = 1'b1;
                  state_nxt     = (score_r_inc == WIN) ? OVER : PAUSE;
               end else if (BHmax >= borderHmax) begin
                  score_l_nxt   = score_l_inc;
                  serve_dir_nxt = 1'b1;
                  center_nxt    = 1'b1;
                  state_nxt     = (score_l_inc == WIN) ? OVER : PAUSE;
               end
            end
         end
         PAUSE: begin
            if (pause_done) begin
`ifdef AUTO_SERVE_EN
               state_nxt = PLAY;
`else
               state_nxt = IDLE;
`endif
            end
         end
         OVER: begin
            if (serve_press) begin
               score_l_nxt   = '0;
               score_r_nxt   = '0;
               serve_dir_nxt = 1'b1;
               center_nxt    = 1'b1;
               state_nxt     = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers. Reset leaves ball_center high so the ball
   // is recentred in the first cycle after reset is released.
   always_ff @(posedge CLK_100MHz) begin
      if (Reset) begin
         state       <= IDLE;
         serve_btn_q <= 1'b0;
         score_L     <= '0;
         score_R     <= '0;
         serve_dir   <= 1'b1;
         ball_center <= 1'b1;
      end else begin
         state       <= state_nxt;
         serve_btn_q <= serve_btn;
         score_L     <= score_l_nxt;
         score_R     <= score_r_nxt;
         serve_dir   <= serve_dir_nxt;
         ball_center <= center_nxt;
      end
   end

endmodule
